// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: CPU register map, VC bit position and default width.
package cardinal_nic_pkg;

  localparam int NIC_DATA_W = 64;
  localparam int NIC_VC_BIT = NIC_DATA_W - 1;
  localparam int NIC_OCC_LSB = 8;

  localparam logic [1:0] NIC_ADDR_IB  = 2'b00;
  localparam logic [1:0] NIC_ADDR_IBS = 2'b01;
  localparam logic [1:0] NIC_ADDR_OB  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OBS = 2'b11;

  // The VC bit is the packet MSB for whatever width the NIC is built with.
  function automatic int vc_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/cardinal_nic_fifo.sv
// Power-of-two FIFO with wrapping pointers and an occupancy counter; storage is not reset.
module cardinal_nic_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the same edge frees the head slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (!RESET && do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cardinal_nic_q.sv
// Cardinal NIC: CPU-side register interface bridging an input and an output packet FIFO to the ring router.
// Optional build macro CARDINAL_NIC_OCC_EN adds FIFO occupancy to the status registers.
module cardinal_nic_q
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = NIC_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int VC = vc_bit(DATA_W);

  logic              ib_push, ib_pop, ib_full, ib_empty;
  logic              ob_push, ob_pop, ob_full, ob_empty;
  logic [DATA_W-1:0] ib_head, ob_head;
  logic [CW-1:0]     ib_count, ob_count;
  logic              rd_vld_p0, wr_vld_p0;
  logic [DATA_W-1:0] rd_data_p0;
  logic              unused_cnt;

  assign unused_cnt = ^{ib_count, ob_count};

  // Stage p0: combinational handshakes and CPU decode
  assign rd_vld_p0 = nicEn && !nicWrEn && !RESET;
  assign wr_vld_p0 = nicEn &&  nicWrEn && !RESET;

  assign net_ri  = !RESET && !ib_full;
  assign ib_push = net_si && net_ri;
  assign ib_pop  = rd_vld_p0 && (addr == NIC_ADDR_IB) && !ib_empty;

  assign net_so  = !RESET && !ob_empty && (ob_head[VC] == net_polarity);
  assign net_do  = ob_head;
  assign ob_pop  = net_so && net_ro;
  assign ob_push = wr_vld_p0 && (addr == NIC_ADDR_OB);

  always_comb begin
    rd_data_p0 = '0;
    case (addr)
      NIC_ADDR_IB: begin
        if (!ib_empty) rd_data_p0 = ib_head;
      end
      NIC_ADDR_IBS: begin
        rd_data_p0[0] = !ib_empty;
`ifdef CARDINAL_NIC_OCC_EN
        rd_data_p0[NIC_OCC_LSB +: CW] = ib_count;
`endif
      end
      NIC_ADDR_OBS: begin
        rd_data_p0[0] = ob_full;
`ifdef CARDINAL_NIC_OCC_EN
        rd_data_p0[NIC_OCC_LSB +: CW] = ob_count;
`endif
      end
      default: rd_data_p0 = '0;
    endcase
  end

  // Stage p1: registered CPU read data, held between reads
  always_ff @(posedge CLK) begin
    if (RESET)          d_out <= '0;
    else if (rd_vld_p0) d_out <= rd_data_p0;
  end

  cardinal_nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ib (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (ib_push),
    .pop   (ib_pop),
    .din   (net_di),
    .dout  (ib_head),
    .full  (ib_full),
    .empty (ib_empty),
    .count (ib_count)
  );

  cardinal_nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ob (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (ob_push),
    .pop   (ob_pop),
    .din   (d_in),
    .dout  (ob_head),
    .full  (ob_full),
    .empty (ob_empty),
    .count (ob_count)
  );

endmodule
